// File: rtl/ps_pkg.sv
// Shared definitions for the program sequencer: sticky-bit indices and the
// run/idle state encoding.
package ps_pkg;

  localparam int STKY_EMPTY = 0;
  localparam int STKY_FULL  = 1;
  localparam int STKY_OVF   = 2;
  localparam int STKY_UNF   = 3;

  typedef enum logic {
    PS_RUN  = 1'b0,
    PS_IDLE = 1'b1
  } ps_state_t;

endpackage

// File: rtl/ps_pc_stack.sv
// PC stack with entry count and sticky empty/full/overflow/underflow status.
// A push on a full stack or a pop on an empty one leaves the pointer alone.
module ps_pc_stack
  import ps_pkg::*;
#(
  parameter int AW        = 16,
  parameter int STK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                push_dt,
  input  logic                         wr,
  input  logic [AW-1:0]                wr_dt,
  input  logic                         stky_clr,
  output logic [AW-1:0]                top,
  output logic [$clog2(STK_DEPTH):0]   count,
  output logic [3:0]                   stky
);

  localparam int IW = $clog2(STK_DEPTH);
  localparam logic [IW:0] ONE_C  = 1;
  localparam logic [IW:0] FULL_C = STK_DEPTH[IW:0];

  logic [AW-1:0] mem [STK_DEPTH];
  logic [IW:0]   cnt;
  logic [IW:0]   cnt_m1;
  logic          ovf;
  logic          unf;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Simultaneous push and pop cancel out.
  assign do_push = push & ~pop;
  assign do_pop  = pop & ~push;
  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_C);
  assign cnt_m1  = cnt - ONE_C;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (do_push && !full)
        cnt <= cnt + ONE_C;
      else if (do_pop && !empty)
        cnt <= cnt_m1;
      if (do_push && full)
        ovf <= 1'b1;
      else if (stky_clr)
        ovf <= 1'b0;
      if (do_pop && empty)
        unf <= 1'b1;
      else if (stky_clr)
        unf <= 1'b0;
    end
  end

  // Entry storage has no reset; only the count defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !full)
      mem[cnt[IW-1:0]] <= push_dt;
    if (wr && !pop && !empty)
      mem[cnt_m1[IW-1:0]] <= wr_dt;
  end

  assign top   = empty ? '0 : mem[cnt_m1[IW-1:0]];
  assign count = cnt;

  always_comb begin
    stky             = 4'b0000;
    stky[STKY_EMPTY] = empty;
    stky[STKY_FULL]  = full;
    stky[STKY_OVF]   = ovf;
    stky[STKY_UNF]   = unf;
  end

endmodule

// File: rtl/ps_seq_core.sv
// Program sequencer core: fetch/decode/execute address pipeline, flow-control
// priority (ret > call > jmp > sequential), PC stack and run/idle control.
module ps_seq_core
  import ps_pkg::*;
#(
  parameter int            AW        = 16,
  parameter int            STK_DEPTH = 4,
  parameter logic [AW-1:0] RST_VEC   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        jmp_en,
  input  logic                        call_en,
  input  logic                        ret_en,
  input  logic [AW-1:0]               jmp_addr,
  input  logic                        psh_en,
  input  logic                        pop_en,
  input  logic                        stk_wr_en,
  input  logic [AW-1:0]               stk_wr_dt,
  input  logic                        idle_en,
  input  logic                        wake,
  input  logic                        stky_clr,
  output logic [AW-1:0]               pm_add,
  output logic                        pm_cslt,
  output logic [AW-1:0]               daddr,
  output logic [AW-1:0]               pc,
  output logic                        dcd_vld,
  output logic                        exe_vld,
  output logic [AW-1:0]               stk_top,
  output logic [$clog2(STK_DEPTH):0]  stk_ptr,
  output logic [3:0]                  stky
);

  localparam logic [AW-1:0] A_ONE = 1;

  ps_state_t     state;
  logic [AW-1:0] faddr;
  logic          warm;
  logic          act;
  logic          do_ret;
  logic          do_call;
  logic          do_jmp;
  logic          flush;
  logic          do_idle;
  logic          s_push;
  logic          s_pop;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] target;

  // Execute-stage inputs only count for a valid instruction while running.
  assign act     = exe_vld & (state == PS_RUN);
  assign do_ret  = act & ret_en;
  assign do_call = act & call_en & ~ret_en;
  assign do_jmp  = act & jmp_en & ~ret_en & ~call_en;
  assign flush   = do_ret | do_call | do_jmp;
  assign do_idle = act & idle_en & ~flush;
  assign s_push  = do_call | (act & ~ret_en & ~call_en & psh_en & ~pop_en);
  assign s_pop   = do_ret  | (act & ~ret_en & ~call_en & pop_en & ~psh_en);
  assign pc_inc  = pc + A_ONE;
  assign target  = do_ret ? stk_top : jmp_addr;
  assign pm_add  = faddr;

  ps_pc_stack #(
    .AW        (AW),
    .STK_DEPTH (STK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (s_push),
    .pop      (s_pop),
    .push_dt  (pc_inc),
    .wr       (act & stk_wr_en),
    .wr_dt    (stk_wr_dt),
    .stky_clr (stky_clr),
    .top      (stk_top),
    .count    (stk_ptr),
    .stky     (stky)
  );

  // warm marks the first cycle after wake: the chip select has just come back,
  // so that cycle's fetch is discarded and faddr is held for one more cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= PS_RUN;
      faddr   <= RST_VEC;
      daddr   <= RST_VEC;
      pc      <= RST_VEC;
      pm_cslt <= 1'b1;
      dcd_vld <= 1'b0;
      exe_vld <= 1'b0;
      warm    <= 1'b0;
    end else begin
      case (state)
        PS_RUN: begin
          daddr <= faddr;
          pc    <= daddr;
          if (warm) begin
            warm    <= 1'b0;
            dcd_vld <= 1'b0;
            exe_vld <= 1'b0;
          end else if (flush) begin
            faddr   <= target;
            dcd_vld <= 1'b0;
            exe_vld <= 1'b0;
          end else if (do_idle) begin
            faddr   <= pc_inc;
            pm_cslt <= 1'b0;
            dcd_vld <= 1'b0;
            exe_vld <= 1'b0;
            state   <= PS_IDLE;
          end else begin
            faddr   <= faddr + A_ONE;
            dcd_vld <= 1'b1;
            exe_vld <= dcd_vld;
          end
        end
        PS_IDLE: begin
          if (wake) begin
            pm_cslt <= 1'b1;
            warm    <= 1'b1;
            state   <= PS_RUN;
          end
        end
        default: state <= PS_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_seq_core.sv
// Directed bench for ps_seq_core: fetch, call/return, overflow, underflow,
// conflict cases, idle/wake and reset while idle.
module tb_ps_seq_core;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          jmp_en = 0, call_en = 0, ret_en = 0;
  logic [AW-1:0] jmp_addr = '0;
  logic          psh_en = 0, pop_en = 0, stk_wr_en = 0;
  logic [AW-1:0] stk_wr_dt = '0;
  logic          idle_en = 0, wake = 0, stky_clr = 0;
  logic [AW-1:0] pm_add, daddr, pc, stk_top;
  logic          pm_cslt, dcd_vld, exe_vld;
  logic [2:0]    stk_ptr;
  logic [3:0]    stky;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_q[$];

  ps_seq_core #(.AW(AW), .STK_DEPTH(4), .RST_VEC('0)) dut (
    .clk(clk), .rst(rst), .jmp_en(jmp_en), .call_en(call_en), .ret_en(ret_en),
    .jmp_addr(jmp_addr), .psh_en(psh_en), .pop_en(pop_en),
    .stk_wr_en(stk_wr_en), .stk_wr_dt(stk_wr_dt), .idle_en(idle_en),
    .wake(wake), .stky_clr(stky_clr), .pm_add(pm_add), .pm_cslt(pm_cslt),
    .daddr(daddr), .pc(pc), .dcd_vld(dcd_vld), .exe_vld(exe_vld),
    .stk_top(stk_top), .stk_ptr(stk_ptr), .stky(stky)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    jmp_en = 0; call_en = 0; ret_en = 0; psh_en = 0; pop_en = 0;
    stk_wr_en = 0; idle_en = 0; wake = 0; stky_clr = 0;
  endtask

  task automatic wait_exe();
    for (int i = 0; i < 10 && !exe_vld; i++) tick();
    check("wait_exe", {31'd0, exe_vld}, 32'd1);
  endtask

  // kind: 0 jump, 1 call, 2 return, 3 return+call together
  task automatic redirect(input int kind, input logic [AW-1:0] addr);
    wait_exe();
    jmp_addr = addr;
    jmp_en   = (kind == 0);
    call_en  = (kind == 1) || (kind == 3);
    ret_en   = (kind == 2) || (kind == 3);
    tick();
    clear_inputs();
  endtask

  task automatic settle(input logic [AW-1:0] exp_pc);
    check("flush_exe0", {31'd0, exe_vld}, 32'd0);
    tick();
    check("flush_exe1", {31'd0, exe_vld}, 32'd0);
    tick();
    check("tgt_exe_vld", {31'd0, exe_vld}, 32'd1);
    check("tgt_pc", {16'd0, pc}, {16'd0, exp_pc});
  endtask

  task automatic pulse_stack(input logic p, input logic q, input logic w, input logic [AW-1:0] d);
    wait_exe();
    psh_en = p; pop_en = q; stk_wr_en = w; stk_wr_dt = d;
    tick();
    clear_inputs();
  endtask

  initial begin
    // reset state
    tick();
    check("rst_pm_add", {16'd0, pm_add}, 32'h0);
    check("rst_cslt", {31'd0, pm_cslt}, 32'd1);
    check("rst_vld", {30'd0, dcd_vld, exe_vld}, 32'd0);
    check("rst_ptr", {29'd0, stk_ptr}, 32'd0);
    check("rst_stky", {28'd0, stky}, 32'h1);
    check("rst_top", {16'd0, stk_top}, 32'h0);
    rst = 1'b1;

    // sequential fetch: 0..4, exe_vld in third cycle with pc=0
    for (int i = 0; i < 5; i++) exp_q.push_back(AW'(i));
    for (int i = 0; i < 5; i++) begin
      logic [AW-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("seq_pm_add%0d", i), {16'd0, pm_add}, {16'd0, e});
      if (i == 1) check("seq_exe_lo", {31'd0, exe_vld}, 32'd0);
      if (i == 2) begin
        check("seq_exe_hi", {31'd0, exe_vld}, 32'd1);
        check("seq_pc0", {16'd0, pc}, 32'h0);
      end
      if (i < 4) tick();
    end

    // get to pc=0x0010, then call 0x0040
    redirect(0, 16'h0010);
    check("jmp_pm_add", {16'd0, pm_add}, 32'h0010);
    settle(16'h0010);
    redirect(1, 16'h0040);
    check("call_pm_add", {16'd0, pm_add}, 32'h0040);
    check("call_top", {16'd0, stk_top}, 32'h0011);
    check("call_ptr", {29'd0, stk_ptr}, 32'd1);
    settle(16'h0040);
    redirect(2, 16'h0000);
    check("ret_pm_add", {16'd0, pm_add}, 32'h0011);
    check("ret_ptr", {29'd0, stk_ptr}, 32'd0);
    check("ret_stky", {28'd0, stky}, 32'h1);
    settle(16'h0011);

    // overflow: pushes 0x12, 0x101, 0x201, 0x301; fifth call is dropped
    for (int i = 1; i <= 5; i++) begin
      redirect(1, AW'(i * 256));
      check($sformatf("ovf_pm_add%0d", i), {16'd0, pm_add}, i * 256);
      settle(AW'(i * 256));
    end
    check("ovf_ptr", {29'd0, stk_ptr}, 32'd4);
    check("ovf_stky", {28'd0, stky}, 32'h6);
    check("ovf_top", {16'd0, stk_top}, 32'h0301);
    stky_clr = 1; tick(); stky_clr = 0;
    check("clr_stky", {28'd0, stky}, 32'h2);

    // ret and call together: return wins
    redirect(3, 16'h0700);
    check("rc_pm_add", {16'd0, pm_add}, 32'h0301);
    check("rc_ptr", {29'd0, stk_ptr}, 32'd3);
    check("rc_top", {16'd0, stk_top}, 32'h0201);
    settle(16'h0301);

    // psh+pop together, then pop, then write top, then push (pc=0x304)
    pulse_stack(1, 1, 0, '0);
    check("pp_ptr", {29'd0, stk_ptr}, 32'd3);
    check("pp_top", {16'd0, stk_top}, 32'h0201);
    pulse_stack(0, 1, 0, '0);
    check("pop_ptr", {29'd0, stk_ptr}, 32'd2);
    check("pop_top", {16'd0, stk_top}, 32'h0101);
    pulse_stack(0, 0, 1, 16'hBEEF);
    check("wr_top", {16'd0, stk_top}, 32'hBEEF);
    check("wr_ptr", {29'd0, stk_ptr}, 32'd2);
    pulse_stack(1, 0, 0, '0);
    check("psh_top", {16'd0, stk_top}, 32'h0305);
    check("psh_ptr", {29'd0, stk_ptr}, 32'd3);

    // drain and underflow
    for (int i = 0; i < 3; i++) pulse_stack(0, 1, 0, '0);
    check("drain_stky", {28'd0, stky}, 32'h1);
    redirect(2, 16'h1234);
    check("unf_pm_add", {16'd0, pm_add}, 32'h0);
    check("unf_stky", {28'd0, stky}, 32'h9);
    check("unf_ptr", {29'd0, stk_ptr}, 32'd0);
    settle(16'h0000);

    // idle at pc=0x0020
    redirect(0, 16'h0020);
    settle(16'h0020);
    idle_en = 1; tick(); clear_inputs();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("idle_cslt%0d", i), {31'd0, pm_cslt}, 32'd0);
      check($sformatf("idle_faddr%0d", i), {16'd0, pm_add}, 32'h0021);
      jmp_en = 1; jmp_addr = 16'h0999;
      tick();
    end
    clear_inputs();
    wake = 1; tick(); wake = 0;
    check("wake_cslt", {31'd0, pm_cslt}, 32'd1);
    check("wake_faddr", {16'd0, pm_add}, 32'h0021);
    tick();
    check("wake_exe1", {31'd0, exe_vld}, 32'd0);
    tick();
    check("wake_exe2", {31'd0, exe_vld}, 32'd0);
    tick();
    check("wake_exe3", {31'd0, exe_vld}, 32'd1);
    check("wake_pc", {16'd0, pc}, 32'h0021);

    // reset while idle
    idle_en = 1; tick(); clear_inputs();
    check("idle2_cslt", {31'd0, pm_cslt}, 32'd0);
    rst = 1'b0;
    #1;
    check("ridle_cslt", {31'd0, pm_cslt}, 32'd1);
    check("ridle_pm_add", {16'd0, pm_add}, 32'h0);
    check("ridle_stky", {28'd0, stky}, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    check("ridle_run", {16'd0, pm_add}, 32'h1);
    check("ridle_dcd", {31'd0, dcd_vld}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
